// File: rtl/hci_pkg.sv
// Shared definitions for the HCI command sequencer: descriptor field layout,
// response layout, error codes and the sequencer state encoding.
package hci_pkg;

    localparam int unsigned CmdAttrLsb    = 0;
    localparam int unsigned CmdAttrW      = 3;
    localparam int unsigned CmdTidLsb     = 3;
    localparam int unsigned CmdTidW       = 4;
    localparam int unsigned CmdDevAddrLsb = 16;
    localparam int unsigned CmdDevAddrW   = 7;
    localparam int unsigned CmdRnwBit     = 29;
    localparam int unsigned CmdLenLsb     = 48;
    localparam int unsigned CmdLenW       = 16;

    localparam int unsigned RespErrLsb = 28;
    localparam int unsigned RespTidLsb = 24;
    localparam int unsigned RespLenLsb = 0;

    localparam logic [3:0] ErrSuccess     = 4'h0;
    localparam logic [3:0] ErrAbort       = 4'h6;
    localparam logic [3:0] ErrUnsupported = 4'h8;
    localparam logic [3:0] ErrTimeout     = 4'hA;

    typedef enum logic [2:0] {
        SeqIdle,
        SeqDecode,
        SeqReq,
        SeqWrite,
        SeqRead,
        SeqDrain,
        SeqWaitDone,
        SeqResp
    } seq_state_e;

    // 17-bit so that a length of 0xFFFF rounds up to 16384 words without wrapping
    function automatic logic [16:0] len_to_words(input logic [15:0] len);
        logic [16:0] sum;
        sum = {1'b0, len} + 17'd3;
        return {2'b00, sum[16:2]};
    endfunction

    function automatic logic [31:0] pack_resp(input logic [3:0]  err,
                                              input logic [3:0]  tid,
                                              input logic [15:0] len);
        logic [31:0] d;
        d = '0;
        d[RespErrLsb +: 4]  = err;
        d[RespTidLsb +: 4]  = tid;
        d[RespLenLsb +: 16] = len;
        return d;
    endfunction

endpackage

// File: rtl/hci_cmd_sequencer_if.sv
// Queue and bus-engine signals seen by the HCI command sequencer.
// master = sequencer side, slave = queues plus bus engine side.
interface hci_cmd_sequencer_if #(
    parameter int unsigned CmdFifoWidth  = 64,
    parameter int unsigned TxFifoWidth   = 32,
    parameter int unsigned RxFifoWidth   = 32,
    parameter int unsigned RespFifoWidth = 32
);
    logic                     cmd_fifo_rvalid_i;
    logic                     cmd_fifo_rready_o;
    logic [CmdFifoWidth-1:0]  cmd_fifo_rdata_i;
    logic                     tx_fifo_rvalid_i;
    logic                     tx_fifo_rready_o;
    logic [TxFifoWidth-1:0]   tx_fifo_rdata_i;
    logic                     rx_fifo_wvalid_o;
    logic                     rx_fifo_wready_i;
    logic [RxFifoWidth-1:0]   rx_fifo_wdata_o;
    logic                     resp_fifo_wvalid_o;
    logic                     resp_fifo_wready_i;
    logic [RespFifoWidth-1:0] resp_fifo_wdata_o;
    logic                     xfer_req_o;
    logic                     xfer_ack_i;
    logic                     xfer_rnw_o;
    logic [6:0]               xfer_addr_o;
    logic [15:0]              xfer_len_o;
    logic                     xfer_tx_valid_o;
    logic                     xfer_tx_ready_i;
    logic [TxFifoWidth-1:0]   xfer_tx_data_o;
    logic                     xfer_rx_valid_i;
    logic                     xfer_rx_ready_o;
    logic [RxFifoWidth-1:0]   xfer_rx_data_i;
    logic                     xfer_done_i;
    logic [3:0]               xfer_err_i;

    modport master (
        input  cmd_fifo_rvalid_i, cmd_fifo_rdata_i, tx_fifo_rvalid_i, tx_fifo_rdata_i,
               rx_fifo_wready_i, resp_fifo_wready_i, xfer_ack_i, xfer_tx_ready_i,
               xfer_rx_valid_i, xfer_rx_data_i, xfer_done_i, xfer_err_i,
        output cmd_fifo_rready_o, tx_fifo_rready_o, rx_fifo_wvalid_o, rx_fifo_wdata_o,
               resp_fifo_wvalid_o, resp_fifo_wdata_o, xfer_req_o, xfer_rnw_o, xfer_addr_o,
               xfer_len_o, xfer_tx_valid_o, xfer_tx_data_o, xfer_rx_ready_o
    );

    modport slave (
        output cmd_fifo_rvalid_i, cmd_fifo_rdata_i, tx_fifo_rvalid_i, tx_fifo_rdata_i,
               rx_fifo_wready_i, resp_fifo_wready_i, xfer_ack_i, xfer_tx_ready_i,
               xfer_rx_valid_i, xfer_rx_data_i, xfer_done_i, xfer_err_i,
        input  cmd_fifo_rready_o, tx_fifo_rready_o, rx_fifo_wvalid_o, rx_fifo_wdata_o,
               resp_fifo_wvalid_o, resp_fifo_wdata_o, xfer_req_o, xfer_rnw_o, xfer_addr_o,
               xfer_len_o, xfer_tx_valid_o, xfer_tx_data_o, xfer_rx_ready_o
    );
endinterface

// File: rtl/hci_seq_watchdog.sv
// Data-phase watchdog for the HCI sequencer (used only with I3C_SEQ_TIMEOUT_EN).
// Down-counter reloaded while idle or on progress; expired_o pulses at terminal count.
module hci_seq_watchdog #(
    parameter int unsigned TimeoutCycles = 65535
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic run_i,
    input  logic clear_i,
    output logic expired_o
);
    logic [31:0] r_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt     <= 32'(TimeoutCycles);
            expired_o <= 1'b0;
        end else if (!run_i || clear_i) begin
            r_cnt     <= 32'(TimeoutCycles);
            expired_o <= 1'b0;
        end else begin
            if (r_cnt != 32'd0) begin
                r_cnt <= r_cnt - 32'd1;
            end
            expired_o <= (r_cnt == 32'd1);
        end
    end
endmodule

// File: rtl/hci_cmd_sequencer.sv
// HCI command sequencer: pops command descriptors, drives the bus engine, moves
// TX/RX words and pushes one response per command. Optional watchdog: I3C_SEQ_TIMEOUT_EN.
//
// state       | meaning
// SeqIdle     | waiting for a command (fetch only while enable_i)
// SeqDecode   | check descriptor attributes
// SeqReq      | transfer request held until bus ack
// SeqWrite    | TX FIFO passes through to bus write stream
// SeqRead     | bus read stream passes through to RX FIFO
// SeqDrain    | discard leftover TX words of an ended write
// SeqWaitDone | waiting for bus completion
// SeqResp     | response descriptor presented until accepted
module hci_cmd_sequencer
    import hci_pkg::*;
#(
    parameter int unsigned CmdFifoWidth  = 64,
    parameter int unsigned TxFifoWidth   = 32,
    parameter int unsigned RxFifoWidth   = 32,
    parameter int unsigned RespFifoWidth = 32,
    parameter int unsigned TimeoutCycles = 65535
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                enable_i,
    input  logic                abort_i,
    output logic                busy_o,
    hci_cmd_sequencer_if.master bus
);
    seq_state_e  r_state;
    logic [2:0]  r_attr;
    logic [3:0]  r_tid;
    logic [6:0]  r_addr;
    logic        r_rnw;
    logic [15:0] r_len;
    logic [16:0] r_words;
    logic [16:0] r_count;
    logic [16:0] r_beats;
    logic [3:0]  r_err;

    logic [CmdFifoWidth-1:0]  w_cmd;
    logic [TxFifoWidth-1:0]   w_tx_data;
    logic [RxFifoWidth-1:0]   w_rx_data;
    logic [RespFifoWidth-1:0] w_resp_data;
    logic        w_tx_beat, w_rx_beat, w_drain_pop, w_step;
    logic [16:0] w_count_next;
    logic        w_timeout, w_stop;
    logic [3:0]  w_stop_err;
    logic [18:0] w_beat_bytes;
    logic [15:0] w_resp_len;
    logic        w_unused;

    assign w_cmd        = bus.cmd_fifo_rdata_i;
    assign w_tx_beat    = (r_state == SeqWrite) && bus.tx_fifo_rvalid_i && bus.xfer_tx_ready_i;
    assign w_rx_beat    = (r_state == SeqRead) && bus.xfer_rx_valid_i && bus.rx_fifo_wready_i;
    // stop popping once aligned so the next command's words stay in the FIFO
    assign w_drain_pop  = (r_state == SeqDrain) && (r_count != r_words) && bus.tx_fifo_rvalid_i;
    assign w_step       = w_tx_beat || w_rx_beat || w_drain_pop;
    assign w_count_next = r_count + {16'd0, w_step};
    assign w_stop       = abort_i || w_timeout;
    assign w_stop_err   = abort_i ? ErrAbort : ErrTimeout;

    assign w_beat_bytes = {r_beats, 2'b00};
    assign w_resp_len   = ((r_err == ErrSuccess) || (r_err == ErrUnsupported)) ? r_len :
                          (w_beat_bytes < {3'b000, r_len}) ? w_beat_bytes[15:0] : r_len;

    assign w_tx_data   = (r_state == SeqWrite) ? bus.tx_fifo_rdata_i : '0;
    assign w_rx_data   = (r_state == SeqRead) ? bus.xfer_rx_data_i : '0;
    assign w_resp_data = (r_state == SeqResp) ? RespFifoWidth'(pack_resp(r_err, r_tid, w_resp_len)) : '0;

    assign bus.cmd_fifo_rready_o  = (r_state == SeqIdle) && enable_i;
    assign bus.xfer_req_o         = (r_state == SeqReq);
    assign bus.xfer_rnw_o         = r_rnw;
    assign bus.xfer_addr_o        = r_addr;
    assign bus.xfer_len_o         = r_len;
    assign bus.xfer_tx_valid_o    = (r_state == SeqWrite) && bus.tx_fifo_rvalid_i;
    assign bus.xfer_tx_data_o     = w_tx_data;
    assign bus.tx_fifo_rready_o   = ((r_state == SeqWrite) && bus.xfer_tx_ready_i) ||
                                    ((r_state == SeqDrain) && (r_count != r_words));
    assign bus.rx_fifo_wvalid_o   = (r_state == SeqRead) && bus.xfer_rx_valid_i;
    assign bus.rx_fifo_wdata_o    = w_rx_data;
    assign bus.xfer_rx_ready_o    = (r_state == SeqRead) && bus.rx_fifo_wready_i;
    assign bus.resp_fifo_wvalid_o = (r_state == SeqResp);
    assign bus.resp_fifo_wdata_o  = w_resp_data;
    assign busy_o                 = (r_state != SeqIdle);

    assign w_unused = ^{w_cmd[15:7], w_cmd[28:23], w_cmd[47:30], 32'(TimeoutCycles)};

`ifdef I3C_SEQ_TIMEOUT_EN
    logic w_wd_run, w_wd_progress;
    assign w_wd_run      = (r_state == SeqReq) || (r_state == SeqWrite) ||
                           (r_state == SeqRead) || (r_state == SeqWaitDone);
    assign w_wd_progress = (bus.xfer_req_o && bus.xfer_ack_i) || w_tx_beat || w_rx_beat ||
                           bus.xfer_done_i;

    hci_seq_watchdog #(.TimeoutCycles(TimeoutCycles)) u_watchdog (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .run_i     (w_wd_run),
        .clear_i   (w_wd_progress),
        .expired_o (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= SeqIdle;
            r_attr  <= '0;
            r_tid   <= '0;
            r_addr  <= '0;
            r_rnw   <= 1'b0;
            r_len   <= '0;
            r_words <= '0;
            r_count <= '0;
            r_beats <= '0;
            r_err   <= ErrSuccess;
        end else begin
            case (r_state)
                SeqIdle: begin
                    if (enable_i && bus.cmd_fifo_rvalid_i) begin
                        r_attr  <= w_cmd[CmdAttrLsb +: CmdAttrW];
                        r_tid   <= w_cmd[CmdTidLsb +: CmdTidW];
                        r_addr  <= w_cmd[CmdDevAddrLsb +: CmdDevAddrW];
                        r_rnw   <= w_cmd[CmdRnwBit];
                        r_len   <= w_cmd[CmdLenLsb +: CmdLenW];
                        r_words <= len_to_words(w_cmd[CmdLenLsb +: CmdLenW]);
                        r_count <= '0;
                        r_beats <= '0;
                        r_err   <= ErrSuccess;
                        r_state <= SeqDecode;
                    end
                end
                SeqDecode: begin
                    if (r_attr != 3'd0) begin
                        r_err   <= ErrUnsupported;
                        r_state <= SeqResp;
                    end else begin
                        r_state <= SeqReq;
                    end
                end
                SeqReq: begin
                    if (w_stop) begin
                        r_err   <= w_stop_err;
                        r_state <= SeqResp;
                    end else if (bus.xfer_ack_i) begin
                        if (r_words == 17'd0)  r_state <= SeqWaitDone;
                        else if (r_rnw)        r_state <= SeqRead;
                        else                   r_state <= SeqWrite;
                    end
                end
                SeqWrite: begin
                    r_count <= w_count_next;
                    r_beats <= r_beats + {16'd0, w_tx_beat};
                    if (bus.xfer_done_i) begin
                        r_err   <= bus.xfer_err_i;
                        r_state <= (w_count_next == r_words) ? SeqResp : SeqDrain;
                    end else if (w_stop) begin
                        r_err   <= w_stop_err;
                        r_state <= SeqDrain;
                    end else if (w_count_next == r_words) begin
                        r_state <= SeqWaitDone;
                    end
                end
                SeqRead: begin
                    r_count <= w_count_next;
                    r_beats <= r_beats + {16'd0, w_rx_beat};
                    if (bus.xfer_done_i) begin
                        r_err   <= bus.xfer_err_i;
                        r_state <= SeqResp;
                    end else if (w_stop) begin
                        r_err   <= w_stop_err;
                        r_state <= SeqResp;
                    end else if (w_count_next == r_words) begin
                        r_state <= SeqResp;
                    end
                end
                SeqDrain: begin
                    r_count <= w_count_next;
                    if (w_count_next == r_words) begin
                        r_state <= SeqResp;
                    end
                end
                SeqWaitDone: begin
                    if (bus.xfer_done_i) begin
                        r_err   <= bus.xfer_err_i;
                        r_state <= SeqResp;
                    end else if (w_stop) begin
                        r_err   <= w_stop_err;
                        r_state <= SeqResp;
                    end
                end
                SeqResp: begin
                    if (bus.resp_fifo_wready_i) begin
                        r_state <= SeqIdle;
                    end
                end
                default: r_state <= SeqIdle;
            endcase
        end
    end
endmodule
